// File: rtl/uop_gate_pkg.sv
// uop_gate_pkg: op encodings and FIFO depth shared by the gate pipe.
package uop_gate_pkg;
  typedef enum logic [2:0] {
    GATE_AND  = 3'b000,
    GATE_NAND = 3'b001,
    GATE_OR   = 3'b010,
    GATE_NOR  = 3'b011,
    GATE_XOR  = 3'b100,
    GATE_XNOR = 3'b101,
    GATE_NOT  = 3'b110,
    GATE_ILL  = 3'b111
  } gate_op_t;
  localparam int GATE_FIFO_DEPTH = 2;
endpackage

// File: rtl/uop_gate_comb.sv
// uop_gate_comb: bitwise gate result and illegal-op flag for one operation.
module uop_gate_comb
  import uop_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] z,
  output logic             op_err
);
  always_comb begin
    z = '0;
    op_err = 1'b0;
    case (gate_op_t'(op))
      GATE_AND:  z = x & y;
      GATE_NAND: z = ~(x & y);
      GATE_OR:   z = x | y;
      GATE_NOR:  z = ~(x | y);
      GATE_XOR:  z = x ^ y;
      GATE_XNOR: z = ~(x ^ y);
      GATE_NOT:  z = ~x;
      default:   op_err = 1'b1;
    endcase
  end
endmodule

// File: rtl/uop_gate_pipe.sv
// uop_gate_pipe: gate op into a 2-entry result FIFO with handshakes and a transfer counter.
// Define UOP_GATE_PIPE_PARITY_EN to add the per-entry z_par output.
module uop_gate_pipe
  import uop_gate_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   z,
  output logic               z_zero,
  output logic               op_err,
`ifdef UOP_GATE_PIPE_PARITY_EN
  output logic               z_par,
`endif
  output logic [COUNT_W-1:0] xfer_count
);
  logic [WIDTH-1:0] c_z;
  logic             c_err;
  logic [WIDTH-1:0] mem_z    [GATE_FIFO_DEPTH];
  logic             mem_zero [GATE_FIFO_DEPTH];
  logic             mem_err  [GATE_FIFO_DEPTH];
  logic             rd, wr, live;
  logic [1:0]       cnt;
  logic             push, pop;

  uop_gate_comb #(.WIDTH(WIDTH)) u_comb (
    .x(x), .y(y), .op(op), .z(c_z), .op_err(c_err)
  );

  // live keeps in_ready low through reset and the cycle reset is released in
  assign in_ready  = live && (cnt < 2'(GATE_FIFO_DEPTH));
  assign out_valid = cnt != 2'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign z         = out_valid ? mem_z[rd] : '0;
  assign z_zero    = out_valid && mem_zero[rd];
  assign op_err    = out_valid && mem_err[rd];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      rd         <= 1'b0;
      wr         <= 1'b0;
      live       <= 1'b0;
      xfer_count <= '0;
    end else begin
      live <= 1'b1;
      if (push) begin
        mem_z[wr]    <= c_z;
        mem_zero[wr] <= c_z == '0;
        mem_err[wr]  <= c_err;
        wr           <= ~wr;
      end
      if (pop) begin
        rd         <= ~rd;
        xfer_count <= xfer_count + 1'b1;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

`ifdef UOP_GATE_PIPE_PARITY_EN
  logic mem_par [GATE_FIFO_DEPTH];
  assign z_par = out_valid && mem_par[rd];
  always_ff @(posedge clk) begin
    if (!reset && push) mem_par[wr] <= ^c_z;
  end
`endif
endmodule

// File: tb/tb_uop_gate_pipe.sv
// tb_uop_gate_pipe: directed checks of the gate pipe at WIDTH=8, COUNT_W=4.
module tb_uop_gate_pipe;
  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, out_valid, out_ready, z_zero, op_err;
  logic [7:0] x, y, z;
  logic [2:0] op;
  logic [3:0] xfer_count;
`ifdef UOP_GATE_PIPE_PARITY_EN
  logic       z_par;
`endif
  int checks = 0;
  int errors = 0;

  uop_gate_pipe #(.WIDTH(8), .COUNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .z_zero(z_zero), .op_err(op_err),
`ifdef UOP_GATE_PIPE_PARITY_EN
    .z_par(z_par),
`endif
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    op = o;
    x = a;
    y = b;
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    repeat (2) step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_z", 32'(z), 0);
    chk("rst_z_zero", 32'(z_zero), 0);
    chk("rst_op_err", 32'(op_err), 0);
    chk("rst_xfer", 32'(xfer_count), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    reset = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_out_valid", 32'(out_valid), 0);

    // single NAND with sink ready
    out_ready = 1'b1;
    drive(1'b1, 3'd1, 8'hF0, 8'hCC);
    step();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    chk("nand_valid", 32'(out_valid), 1);
    chk("nand_z", 32'(z), 32'h3F);
    chk("nand_zero", 32'(z_zero), 0);
    chk("nand_err", 32'(op_err), 0);
    step();
    chk("nand_pop_valid", 32'(out_valid), 0);
    chk("nand_pop_z", 32'(z), 0);
    chk("nand_xfer", 32'(xfer_count), 1);

    // fill the FIFO with the sink stalled
    out_ready = 1'b0;
    drive(1'b1, 3'd4, 8'hAA, 8'hAA);
    step();
    chk("fill1_in_ready", 32'(in_ready), 1);
    chk("fill1_z", 32'(z), 0);
    chk("fill1_zero", 32'(z_zero), 1);
    drive(1'b1, 3'd2, 8'h01, 8'h02);
    step();
    chk("fill2_in_ready", 32'(in_ready), 0);
    chk("fill2_z", 32'(z), 0);
    chk("fill2_zero", 32'(z_zero), 1);
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    step();
    chk("hold_valid", 32'(out_valid), 1);
    chk("hold_zero", 32'(z_zero), 1);
    chk("hold_xfer", 32'(xfer_count), 1);
    out_ready = 1'b1;
    step();
    chk("drain1_z", 32'(z), 32'h03);
    chk("drain1_zero", 32'(z_zero), 0);
    chk("drain1_in_ready", 32'(in_ready), 1);
    chk("drain1_xfer", 32'(xfer_count), 2);
    step();
    chk("drain2_valid", 32'(out_valid), 0);
    chk("drain2_xfer", 32'(xfer_count), 3);

    // illegal op followed by a legal AND
    out_ready = 1'b0;
    drive(1'b1, 3'd7, 8'hFF, 8'h00);
    step();
    chk("ill_z", 32'(z), 0);
    chk("ill_err", 32'(op_err), 1);
    chk("ill_zero", 32'(z_zero), 1);
    drive(1'b1, 3'd0, 8'hFF, 8'h0F);
    step();
    chk("ill_head_err", 32'(op_err), 1);
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    out_ready = 1'b1;
    step();
    chk("and_z", 32'(z), 32'h0F);
    chk("and_err", 32'(op_err), 0);
    step();
    chk("and_xfer", 32'(xfer_count), 5);

    // streaming at occupancy 1, counter wraps past 15
    out_ready = 1'b0;
    drive(1'b1, 3'd4, 8'h00, 8'h55);
    step();
    out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 3'd4, 8'(k), 8'h55);
      chk("stream_head", 32'(z), 32'((k - 1) ^ 8'h55));
      step();
      chk("stream_in_ready", 32'(in_ready), 1);
      chk("stream_valid", 32'(out_valid), 1);
      chk("stream_xfer", 32'(xfer_count), 32'((5 + k) % 16));
    end

    // reset with two entries queued
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 8'h3C, 8'h00);
    step();
    chk("q2_in_ready", 32'(in_ready), 0);
    chk("q2_head", 32'(z), 32'h59);
`ifdef UOP_GATE_PIPE_PARITY_EN
    chk("q2_par", 32'(z_par), 32'(^z));
`endif
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_xfer", 32'(xfer_count), 0);
    chk("mid_rst_z", 32'(z), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_stale_valid", 32'(out_valid), 0);
    end
    chk("after_rst_in_ready", 32'(in_ready), 1);
    drive(1'b1, 3'd5, 8'h00, 8'h01);
    step();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    chk("xnor_z", 32'(z), 32'hFE);
`ifdef UOP_GATE_PIPE_PARITY_EN
    chk("xnor_par", 32'(z_par), 1);
`endif
    step();
    chk("final_xfer", 32'(xfer_count), 1);
    chk("final_valid", 32'(out_valid), 0);
`ifdef UOP_GATE_PIPE_PARITY_EN
    chk("final_par", 32'(z_par), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
